// File: rtl/cpubus_pkg.sv
// Shared encodings for the cache CPU-bus arbiter: FSM states and transaction type.
package cpubus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic TR_READ  = 1'b0;
  localparam logic TR_WRITE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: the first valid requester after i_last wins.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_any
);

  int w_last;
  int w_dist;
  int w_best;

  // Distance from the slot after i_last, wrapping; smallest distance among valid requesters wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_last  = int'(i_last);
    w_dist  = 0;
    w_best  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i > w_last) ? (i - w_last - 1) : (i + NUM_REQ - w_last - 1);
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = IDX_W'(i);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpubus_arbiter.sv
// Round-robin arbiter/sequencer for the cache go/done CPU bus.
// Optional done watchdog enabled by defining CPUBUS_ARB_TIMEOUT_EN.
module cpubus_arbiter
  import cpubus_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_error,
  output logic                      transaction_req,
  output logic [ADDR_W-1:0]         cpubus_address,
  output logic [DATA_W-1:0]         cpubus_data,
  output logic                      go,
  input  logic                      done,
  input  logic [DATA_W-1:0]         cpubus_data_reg
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   w_pick;
  logic               w_any;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_timeout;
  logic               r_err;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CPUBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counter is zero on every WAIT entry because it is held clear outside WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_cnt <= '0;
    end else if (!done) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !done &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: WAIT lasts until done.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    go          = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        go          = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant         <= '0;
      r_last_grant    <= IDX_W'(NUM_REQ - 1);
      transaction_req <= TR_READ;
      cpubus_address  <= '0;
      cpubus_data     <= '0;
      req_rdata       <= '0;
      r_err           <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_any) begin
        r_grant         <= w_pick;
        transaction_req <= w_sel_write;
        cpubus_address  <= w_sel_addr;
        cpubus_data     <= w_sel_wdata;
        r_err           <= 1'b0;
      end
      if ((r_state == S_WAIT) && done && (transaction_req == TR_READ)) begin
        req_rdata <= cpubus_data_reg;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == S_RESP) begin
        r_last_grant <= r_grant;
      end
    end
  end

  always_comb begin
    req_done  = '0;
    req_error = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((r_state == S_RESP) && (r_grant == IDX_W'(i))) begin
        req_done[i]  = 1'b1;
        req_error[i] = r_err;
      end
    end
  end

endmodule

// File: tb/tb_cpubus_arbiter.sv
// Directed bench for cpubus_arbiter (NUM_REQ=2, 16-bit address/data).
module tb_cpubus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_done;
  logic [15:0] req_rdata;
  logic [1:0]  req_error;
  logic        transaction_req;
  logic [15:0] cpubus_address;
  logic [15:0] cpubus_data;
  logic        go;
  logic        done;
  logic [15:0] cpubus_data_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpubus_arbiter #(
    .NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_done        (req_done),
    .req_rdata       (req_rdata),
    .req_error       (req_error),
    .transaction_req (transaction_req),
    .cpubus_address  (cpubus_address),
    .cpubus_data     (cpubus_data),
    .go              (go),
    .done            (done),
    .cpubus_data_reg (cpubus_data_reg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    done = 1'b0; cpubus_data_reg = '0;
    tick(); tick();
    chk("rst_go", go, 0);
    chk("rst_done", req_done, 0);
    chk("rst_err", req_error, 0);
    chk("rst_tr", transaction_req, 0);
    chk("rst_addr", cpubus_address, 0);
    chk("rst_data", cpubus_data, 0);
    chk("rst_rdata", req_rdata, 0);
    rst = 1'b1;
    tick();

    // Requester 0 read of 0x0003, two WAIT cycles before done.
    req_valid = 2'b01; req_addr[15:0] = 16'h0003;
    tick();
    chk("rd_go", go, 1);
    chk("rd_addr", cpubus_address, 16'h0003);
    chk("rd_tr", transaction_req, 0);
    tick();
    chk("rd_go_once", go, 0);
    chk("rd_wait_nodone", req_done, 0);
    tick();
    chk("rd_wait2_nodone", req_done, 0);
    done = 1'b1; cpubus_data_reg = 16'h00A5;
    tick();
    chk("rd_done", req_done, 2'b01);
    chk("rd_rdata", req_rdata, 16'h00A5);
    chk("rd_err", req_error, 0);
    done = 1'b0; req_valid = 2'b00;
    tick();
    chk("rd_done_pulse", req_done, 0);
    chk("rd_rdata_hold", req_rdata, 16'h00A5);

    // Requester 1 write; changing inputs after grant must not reach the bus.
    req_valid = 2'b10; req_write = 2'b10; req_addr[31:16] = 16'h0007; req_wdata[31:16] = 16'h1234;
    tick();
    chk("wr_go", go, 1);
    chk("wr_tr", transaction_req, 1);
    chk("wr_addr", cpubus_address, 16'h0007);
    chk("wr_data", cpubus_data, 16'h1234);
    req_addr[31:16] = 16'hFFFF; req_wdata[31:16] = 16'hDEAD;
    tick();
    chk("wr_addr_latched", cpubus_address, 16'h0007);
    tick();
    chk("wr_data_latched", cpubus_data, 16'h1234);
    done = 1'b1; cpubus_data_reg = 16'hBEEF;
    tick();
    chk("wr_done", req_done, 2'b10);
    chk("wr_rdata_unchanged", req_rdata, 16'h00A5);
    done = 1'b0; req_valid = 2'b00; req_write = 2'b00;
    tick();

    // Both requesters valid, done held high: alternating grants 4 cycles apart.
    req_addr = {16'h0020, 16'h0010}; cpubus_data_reg = 16'h0055; done = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_go", go, 1);
      chk("rr_addr", cpubus_address, (k % 2 == 0) ? 16'h0010 : 16'h0020);
      tick();
      chk("rr_wait", req_done, 0);
      tick();
      chk("rr_done", req_done, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 3) req_valid = 2'b00;
      tick();
      chk("rr_idle", req_done, 0);
    end

    // Spurious done while idle.
    tick();
    chk("sp_idle_go", go, 0);
    chk("sp_idle_done", req_done, 0);
    done = 1'b0;

    // Done pulse in ISSUE must not complete the transaction.
    req_valid = 2'b01; cpubus_data_reg = 16'h0777;
    tick();
    chk("sp_issue_go", go, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("sp_issue_nodone", req_done, 0);
    tick();
    chk("sp_issue_still_wait", req_done, 0);
    chk("sp_issue_rdata", req_rdata, 16'h0055);
    done = 1'b1;
    tick();
    chk("sp_final_done", req_done, 2'b01);
    chk("sp_final_rdata", req_rdata, 16'h0777);
    done = 1'b0; req_valid = 2'b00;
    tick();

    // Reset during WAIT; afterwards requester 0 must win again.
    req_valid = 2'b10;
    tick();
    chk("rw_go", go, 1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rw_async_go", go, 0);
    chk("rw_async_done", req_done, 0);
    chk("rw_async_addr", cpubus_address, 0);
    tick();
    rst = 1'b1; done = 1'b1; req_valid = 2'b11;
    tick();
    chk("rw_after_go", go, 1);
    chk("rw_after_addr", cpubus_address, 16'h0010);
    tick();
    tick();
    chk("rw_after_done", req_done, 2'b01);
    done = 1'b0; req_valid = 2'b00;
    tick();

`ifdef CPUBUS_ARB_TIMEOUT_EN
    // Watchdog: 8 WAIT cycles without done force completion with error.
    req_valid = 2'b01;
    tick();
    chk("to_go", go, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("to_wait", req_done, 0);
    end
    tick();
    chk("to_done", req_done, 2'b01);
    chk("to_err", req_error, 2'b01);
    chk("to_rdata", req_rdata, 16'h0777);
    req_valid = 2'b00;
    tick();
    chk("to_err_pulse", req_error, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpubus_arbiter.md
# cpubus_arbiter

Round-robin arbiter and sequencer that shares the tiny cache CPU bus between NUM_REQ requesters. Each requester posts a read or write; the arbiter selects one, drives cpubus_address / transaction_req / cpubus_data, pulses go, waits for done, captures cpubus_data_reg, and returns a one-cycle completion to the winner. Sits between the CPU-side masters (or test drivers) and the cache's go/done bus port.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 16, cpubus_address width
- DATA_W, 16, data width
- TIMEOUT_CYCLES, 255, done watchdog limit (used only with CPUBUS_ARB_TIMEOUT_EN)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request; held high until req_done
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_rdata  out  DATA_W  read data, valid in req_done cycle, held until next completion
- req_error  out  NUM_REQ  one-cycle timeout flag, coincident with req_done (macro only; else tied 0)
- transaction_req  out  1  cache transaction type: 0 read, 1 write
- cpubus_address  out  ADDR_W  registered address to cache
- cpubus_data  out  DATA_W  registered write data to cache
- go  out  1  one-cycle transaction start
- done  in  1  cache completion
- cpubus_data_reg  in  DATA_W  cache read data, valid when done=1

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick winner by round-robin starting at last_grant+1 (mod NUM_REQ); latch index, req_write, addr, wdata into output regs; -> ISSUE. Else stay.
- ISSUE: go=1 exactly this cycle; -> WAIT.
- WAIT: hold bus outputs stable; on done=1 capture cpubus_data_reg into req_rdata (reads only; writes leave req_rdata unchanged); -> RESP.
- RESP: req_done[grant]=1; last_grant <= grant; -> IDLE.
- done outside WAIT is ignored.
- Requester changing req_addr/req_wdata after grant has no effect (latched).
- Requester dropping req_valid before req_done: transaction still completes, req_done still pulses.
- Single active requester: served every 4+ cycles, no starvation penalty.

## Timing
- Reset (rst=0, async): state IDLE, go=0, req_done=0, req_error=0, transaction_req=0, cpubus_address=0, cpubus_data=0, req_rdata=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
- Reset mid-transaction: aborted immediately, go drops asynchronously; the cache's outstanding done after release is ignored (arrives in IDLE).
- Latency: req_valid seen in cycle 0 (IDLE) -> go in cycle 1 -> earliest done in cycle 2 -> req_done cycle 3. Total = 3 + cache wait cycles.
- Back-to-back: IDLE re-arbitrates the cycle after RESP; minimum 4 cycles per transaction.
- Simultaneous requests: exactly one granted; the others are served in rotating order.

## Configuration
- CPUBUS_ARB_TIMEOUT_EN defined: counter cleared on entering WAIT, increments each WAIT cycle without done; reaching TIMEOUT_CYCLES forces -> RESP with req_error[grant]=1, req_rdata unchanged. A late done is ignored.
- Undefined: no counter, WAIT indefinitely; req_error tied 0.

## Structure
- Package cpubus_pkg: state encoding (IDLE/ISSUE/WAIT/RESP), TR_READ=0 / TR_WRITE=1 constants.
- Sub-module rr_picker: combinational round-robin priority selector (req vector + last_grant -> grant index + any_valid).

## Test plan
- Reset then requester 0 read addr 0x0003, cache done after 2 cycles with 0x00A5 -> go once, req_done[0] in cycle 5, req_rdata=0x00A5.
- Requesters 0 and 1 both valid from reset, done after 1 cycle each -> grants 0,1,0,1 alternate; each req_done 4 cycles apart.
- Requester 1 write addr 0x0007 data 0x1234 -> transaction_req=1, cpubus_address=0x0007, cpubus_data=0x1234 stable from go to done; req_rdata unchanged.
- Spurious done in IDLE and ISSUE -> no state change, no req_done.
- rst asserted during WAIT -> go/req_done 0 immediately; after release, next grant goes to requester 0.
- CPUBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, done never asserted -> req_done[0] and req_error[0] pulse together after 8 WAIT cycles.
